// File: rtl/player_pkg.sv
// player_pkg: shared constants, FSM state type and a one-hot helper for the
// drum-machine pattern player.
package player_pkg;

    localparam int NUM_INS         = 4;
    localparam int STEPS           = 8;
    localparam int STEP_W          = 3;
    localparam int GATE_CYCLES_DEF = 2_500_000;   // 50 ms at 50 MHz

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } player_state_t;

    // One-hot LED pattern for a step index.
    function automatic logic [STEPS-1:0] step_onehot(input logic [STEP_W-1:0] s);
        return STEPS'(1) << s;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// gate_timer: per-instrument reloadable gate. A fire produces a one-cycle
// trig and a gate that stays high for GATE_CYCLES cycles; a fire while the
// gate is active restarts the count without dropping the gate.
module gate_timer #(
    parameter int GATE_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic clear,
    output logic trig,
    output logic gate
);

    localparam int                CNT_W = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(GATE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;
    logic             gate_q, gate_d;

    // Next-state: clear beats fire; the counter stops at zero, and the gate
    // covers the load cycle plus the GATE_CYCLES-1 counted cycles after it.
    always_comb begin
        cnt_d  = cnt_q;
        trig_d = 1'b0;
        gate_d = (cnt_q != '0);
        if (clear) begin
            cnt_d  = '0;
            gate_d = 1'b0;
        end else if (fire) begin
            cnt_d  = LOAD;
            trig_d = 1'b1;
            gate_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            trig_q <= 1'b0;
            gate_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
            gate_q <= gate_d;
        end
    end

    assign trig = trig_q;
    assign gate = gate_q;

endmodule

// File: rtl/pattern_player.sv
// pattern_player: stores four 8-step patterns, follows the slow-clock beat
// index and fires per-instrument trig/gate outputs plus a one-hot step LED.
// Optional feature macro: PLAYER_MUTE_EN adds a synchronised per-instrument
// mute input that suppresses new hits.
module pattern_player
    import player_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STEPS-1:0]    data_in,
    input  logic                ld_ins1,
    input  logic                ld_ins2,
    input  logic                ld_ins3,
    input  logic                ld_ins4,
    input  logic                play,
    input  logic [STEP_W-1:0]   timing,
`ifdef PLAYER_MUTE_EN
    input  logic [NUM_INS-1:0]  mute,
`endif
    output logic [NUM_INS-1:0]  trig,
    output logic [NUM_INS-1:0]  gate,
    output logic [STEPS-1:0]    step_led
);

    logic                play_meta_q, play_s_q;
    logic [STEP_W-1:0]   timing_meta_q, timing_s_q, timing_dly_q;
    logic                stable;

    player_state_t       state_q, state_d;
    logic [STEP_W-1:0]   cur_step_q, cur_step_d;
    logic                step_evt, clear;

    logic [NUM_INS-1:0][STEPS-1:0] pat_q, pat_d;
    logic [NUM_INS-1:0]  ld;
    logic [NUM_INS-1:0]  fire;
    logic [NUM_INS-1:0]  enable;

    assign ld = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};

`ifdef PLAYER_MUTE_EN
    logic [NUM_INS-1:0] mute_meta_q, mute_s_q;

    // Two-flop synchroniser for the mute switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mute_meta_q <= '0;
            mute_s_q    <= '0;
        end else begin
            mute_meta_q <= mute;
            mute_s_q    <= mute_meta_q;
        end
    end

    assign enable = ~mute_s_q;
`else
    assign enable = '1;
`endif

    // Two-flop synchronisers for play and the beat index, plus one extra
    // timing stage so a skewed multi-bit change is only accepted once settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            play_meta_q   <= 1'b0;
            play_s_q      <= 1'b0;
            timing_meta_q <= '0;
            timing_s_q    <= '0;
            timing_dly_q  <= '0;
        end else begin
            play_meta_q   <= play;
            play_s_q      <= play_meta_q;
            timing_meta_q <= timing;
            timing_s_q    <= timing_meta_q;
            timing_dly_q  <= timing_s_q;
        end
    end

    assign stable = (timing_s_q == timing_dly_q);

    // Pattern load: only while idle; several enables may load together.
    always_comb begin
        pat_d = pat_q;
        if (state_q == IDLE) begin
            for (int i = 0; i < NUM_INS; i++) begin
                if (ld[i]) pat_d[i] = data_in;
            end
        end
    end

    // Next-state and step-event logic; a play drop wins over a new step.
    always_comb begin
        state_d    = state_q;
        cur_step_d = cur_step_q;
        step_evt   = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (play_s_q) state_d = ARM;
            end
            ARM: begin
                if (!play_s_q) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (stable) begin
                    cur_step_d = timing_s_q;
                    step_evt   = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!play_s_q) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (stable && (timing_s_q != cur_step_q)) begin
                    cur_step_d = timing_s_q;
                    step_evt   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    // State, current step and pattern registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_step_q <= '0;
            pat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_step_q <= cur_step_d;
            pat_q      <= pat_d;
        end
    end

    // The accepted step is always the synchronised index at the event.
    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_INS; i++) begin
            fire[i] = step_evt & pat_q[i][timing_s_q] & enable[i];
        end
    end

    for (genvar gi = 0; gi < NUM_INS; gi++) begin : g_ins
        gate_timer #(
            .GATE_CYCLES (GATE_CYCLES)
        ) u_gate_timer (
            .clk   (clk),
            .reset (reset),
            .fire  (fire[gi]),
            .clear (clear),
            .trig  (trig[gi]),
            .gate  (gate[gi])
        );
    end

    assign step_led = (state_q == RUN) ? step_onehot(cur_step_q) : '0;

endmodule
